// File: rtl/svc_rv_status_pkg.sv
// Purpose: shared types and the LED-pattern helper for the RISC-V run/completion indicator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t - per-channel run state, 2 bits: IDLE=0, RUN=1, DONE=2, TRAP=3
//   led_of  - maps (state, slow, fast) to the LED drive bit
package svc_rv_status_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TRAP = 2'd3
    } state_t;

    // Heartbeat while running, solid when done, fast blink on trap.
    function automatic logic led_of(input state_t st, input logic slow, input logic fast);
        logic v;
        v = 1'b0;
        case (st)
            IDLE:    v = 1'b0;
            RUN:     v = slow;
            DONE:    v = 1'b1;
            TRAP:    v = fast;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/svc_rv_status_ch.sv
// Purpose: one channel's run/done/trap FSM plus its registered LED drive.
// Latency: state updates on the sampling edge; LED follows the state register one cycle later.
// Backpressure: none; all inputs are level-sampled every cycle.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_en              - start: IDLE -> RUN
//   i_clr             - return to IDLE, beats every other input
//   i_done, i_trap    - completion / trap events, honoured only in RUN (trap wins)
//   i_slow, i_fast    - shared blink phases
//   o_state, o_led    - current state register and LED register
module svc_rv_status_ch
    import svc_rv_status_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_en,
    input  logic   i_clr,
    input  logic   i_done,
    input  logic   i_trap,
    input  logic   i_slow,
    input  logic   i_fast,
    output state_t o_state,
    output logic   o_led
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Driven from the current state, so the LED lags the state by one cycle.
            r_led   <= led_of(r_state, i_slow, i_fast);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_en) w_state_nxt = RUN;
                RUN: begin
                    if (i_trap)      w_state_nxt = TRAP;
                    else if (i_done) w_state_nxt = DONE;
                end
                // DONE and TRAP are sticky until clear or reset.
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_led   = r_led;

endmodule

// File: rtl/svc_rv_status_led.sv
// Purpose: per-hart run/completion LED indicator with aggregate all_done / any_trap flags.
// Latency: flags combinational from channel state; LEDs registered, one cycle behind state.
// Backpressure: none; inputs are level-sampled clk-domain pulses, no synchronisers.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - start every IDLE channel
//   clr               - all channels to IDLE, cycles to 0 (blink counter keeps running)
//   done_i, trap_i    - per-channel completion / trap pulses
//   led               - per-channel LED drive (registered)
//   all_done          - every channel in DONE
//   any_trap          - some channel in TRAP
//   cycles            - saturating count of edges with at least one channel in RUN
//
// Optional feature macro: SVC_RV_STATUS_CYCLES_EN builds the run-cycle counter;
// when undefined, cycles is tied to 0 but the port remains.
module svc_rv_status_led
    import svc_rv_status_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int BLINK_DIV  = 24,
    parameter int FAST_SHIFT = 3,
    parameter int CYC_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] done_i,
    input  logic [NUM_CH-1:0] trap_i,
    output logic [NUM_CH-1:0] led,
    output logic              all_done,
    output logic              any_trap,
    output logic [CYC_W-1:0]  cycles
);

    // Free-running blink counter, shared by all channels; clr does not touch it.
    logic [BLINK_DIV-1:0] r_cnt;
    logic                 w_slow;
    logic                 w_fast;

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + 1'b1;
    end

    assign w_slow = r_cnt[BLINK_DIV-1];
    assign w_fast = r_cnt[BLINK_DIV-1-FAST_SHIFT];

    logic [NUM_CH-1:0] w_is_run;
    logic [NUM_CH-1:0] w_is_done;
    logic [NUM_CH-1:0] w_is_trap;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t w_state;

        svc_rv_status_ch u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_en    (en),
            .i_clr   (clr),
            .i_done  (done_i[g]),
            .i_trap  (trap_i[g]),
            .i_slow  (w_slow),
            .i_fast  (w_fast),
            .o_state (w_state),
            .o_led   (led[g])
        );

        assign w_is_run[g]  = (w_state == RUN);
        assign w_is_done[g] = (w_state == DONE);
        assign w_is_trap[g] = (w_state == TRAP);
    end

    assign all_done = &w_is_done;
    assign any_trap = |w_is_trap;

`ifdef SVC_RV_STATUS_CYCLES_EN
    logic [CYC_W-1:0] r_cycles;

    // Counts edges seen while a channel is RUN; saturates rather than wrapping
    // so a long run never reads back as a short one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cycles <= '0;
        end else if ((|w_is_run) && (r_cycles != {CYC_W{1'b1}})) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign cycles = r_cycles;
`else
    logic w_unused_run;
    assign w_unused_run = |w_is_run;
    assign cycles       = '0;
`endif

endmodule

// File: tb/tb_svc_rv_status_led.sv
module tb_svc_rv_status_led;

    localparam int NUM_CH     = 2;
    localparam int BLINK_DIV  = 4;
    localparam int FAST_SHIFT = 2;
    localparam int CYC_W      = 8;

`ifdef SVC_RV_STATUS_CYCLES_EN
    localparam bit CYC_ON = 1'b1;
`else
    localparam bit CYC_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic              clr;
    logic [NUM_CH-1:0] done_i;
    logic [NUM_CH-1:0] trap_i;
    logic [NUM_CH-1:0] led;
    logic              all_done;
    logic              any_trap;
    logic [CYC_W-1:0]  cycles;

    int n_vec;
    int n_err;

    // Reference blink counter: m_cnt is the value after the last edge,
    // prev_cnt the value that was present at that edge (what the LED sampled).
    logic [3:0] m_cnt;
    logic [3:0] prev_cnt;

    svc_rv_status_led #(
        .NUM_CH     (NUM_CH),
        .BLINK_DIV  (BLINK_DIV),
        .FAST_SHIFT (FAST_SHIFT),
        .CYC_W      (CYC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .done_i   (done_i),
        .trap_i   (trap_i),
        .led      (led),
        .all_done (all_done),
        .any_trap (any_trap),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        prev_cnt = m_cnt;
        m_cnt    = r ? 4'd0 : m_cnt + 4'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL reset_led got=%b exp=00", led); end
        n_vec++; if (all_done !== 1'b0) begin n_err++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
        n_vec++; if (any_trap !== 1'b0) begin n_err++; $display("FAIL reset_any_trap got=%b exp=0", any_trap); end
        n_vec++; if (cycles !== 8'd0) begin n_err++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
        n_vec++; if (dut.r_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", dut.r_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_heartbeat();
        en = 1'b1;
        step();
        en = 1'b0;
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL hb_first_led got=%b exp=00", led); end
        for (int i = 0; i < 32; i++) begin
            step();
            n_vec++;
            if (led !== {prev_cnt[3], prev_cnt[3]}) begin
                n_err++; $display("FAIL hb_led[%0d] got=%b exp=%b", i, led, {prev_cnt[3], prev_cnt[3]});
            end
        end
        n_vec++; if (all_done !== 1'b0) begin n_err++; $display("FAIL hb_all_done got=%b exp=0", all_done); end
    endtask

    task automatic test_completion();
        done_i = 2'b01;
        step();
        done_i = 2'b00;
        n_vec++; if (led !== {prev_cnt[3], prev_cnt[3]}) begin n_err++; $display("FAIL cmp_led_lag got=%b exp=%b", led, {prev_cnt[3], prev_cnt[3]}); end
        n_vec++; if (all_done !== 1'b0) begin n_err++; $display("FAIL cmp_all_done_part got=%b exp=0", all_done); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (led !== {prev_cnt[3], 1'b1}) begin n_err++; $display("FAIL cmp_led0_solid[%0d] got=%b exp=%b", i, led, {prev_cnt[3], 1'b1}); end
        end
        // Two-cycle pulse behaves like a single one.
        done_i = 2'b10;
        step();
        step();
        done_i = 2'b00;
        n_vec++; if (all_done !== 1'b1) begin n_err++; $display("FAIL cmp_all_done got=%b exp=1", all_done); end
        n_vec++; if (any_trap !== 1'b0) begin n_err++; $display("FAIL cmp_any_trap got=%b exp=0", any_trap); end
        n_vec++; if (led !== 2'b11) begin n_err++; $display("FAIL cmp_led_solid got=%b exp=11", led); end
        // en and trap in DONE are ignored.
        en = 1'b1; trap_i = 2'b11;
        step();
        en = 1'b0; trap_i = 2'b00;
        step();
        n_vec++; if ({all_done, any_trap, led} !== 4'b1011) begin n_err++; $display("FAIL cmp_sticky got=%b exp=1011", {all_done, any_trap, led}); end
    endtask

    task automatic test_trap();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_vec++; if (all_done !== 1'b0) begin n_err++; $display("FAIL trp_clr_flag got=%b exp=0", all_done); end
        step();
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL trp_clr_led got=%b exp=00", led); end
        en = 1'b1;
        step();
        en = 1'b0;
        trap_i = 2'b10; done_i = 2'b10;
        step();
        trap_i = 2'b00; done_i = 2'b00;
        n_vec++; if (any_trap !== 1'b1) begin n_err++; $display("FAIL trp_any_trap got=%b exp=1", any_trap); end
        n_vec++; if (all_done !== 1'b0) begin n_err++; $display("FAIL trp_all_done got=%b exp=0", all_done); end
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (led !== {prev_cnt[1], prev_cnt[3]}) begin n_err++; $display("FAIL trp_led[%0d] got=%b exp=%b", i, led, {prev_cnt[1], prev_cnt[3]}); end
        end
        // Channel 0 finishes; a trapped channel 1 still blocks all_done.
        done_i = 2'b11;
        step();
        done_i = 2'b00;
        n_vec++; if ({all_done, any_trap} !== 2'b01) begin n_err++; $display("FAIL trp_block_done got=%b exp=01", {all_done, any_trap}); end
    endtask

    task automatic test_clear();
        clr = 1'b1; en = 1'b1; done_i = 2'b01;
        step();
        clr = 1'b0; en = 1'b0; done_i = 2'b00;
        n_vec++; if ({all_done, any_trap} !== 2'b00) begin n_err++; $display("FAIL clr_flags got=%b exp=00", {all_done, any_trap}); end
        n_vec++; if (cycles !== 8'd0) begin n_err++; $display("FAIL clr_cycles got=%0d exp=0", cycles); end
        step();
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL clr_led got=%b exp=00", led); end
        step();
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL clr_idle_hold got=%b exp=00", led); end
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (led !== {prev_cnt[3], prev_cnt[3]}) begin n_err++; $display("FAIL clr_restart[%0d] got=%b exp=%b", i, led, {prev_cnt[3], prev_cnt[3]}); end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if ({led, all_done, any_trap} !== 4'b0000) begin n_err++; $display("FAIL mrst_out got=%b exp=0000", {led, all_done, any_trap}); end
        n_vec++; if (dut.r_cnt !== 4'd0) begin n_err++; $display("FAIL mrst_cnt got=%0d exp=0", dut.r_cnt); end
        step();
        step();
        n_vec++; if (led !== 2'b00) begin n_err++; $display("FAIL mrst_idle got=%b exp=00", led); end
        n_vec++; if (cycles !== 8'd0) begin n_err++; $display("FAIL mrst_cycles got=%0d exp=0", cycles); end
    endtask

    task automatic test_cycles();
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 99; i++) step();
        done_i = 2'b11;
        step();
        done_i = 2'b00;
        n_vec++; if (cycles !== (CYC_ON ? 8'd100 : 8'd0)) begin n_err++; $display("FAIL cyc_100 got=%0d exp=%0d", cycles, CYC_ON ? 100 : 0); end
        for (int i = 0; i < 5; i++) step();
        n_vec++; if (cycles !== (CYC_ON ? 8'd100 : 8'd0)) begin n_err++; $display("FAIL cyc_hold got=%0d exp=%0d", cycles, CYC_ON ? 100 : 0); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_vec++; if (cycles !== 8'd0) begin n_err++; $display("FAIL cyc_clr got=%0d exp=0", cycles); end
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 300; i++) step();
        n_vec++; if (cycles !== (CYC_ON ? 8'd255 : 8'd0)) begin n_err++; $display("FAIL cyc_sat got=%0d exp=%0d", cycles, CYC_ON ? 255 : 0); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_cnt    = 4'd0;
        prev_cnt = 4'd0;
        rst      = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        done_i   = '0;
        trap_i   = '0;

        test_reset();
        test_heartbeat();
        test_completion();
        test_trap();
        test_clear();
        test_mid_reset();
        test_cycles();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
